pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Instruction-fetch stage: holds the program counter, issues one instruction-memory
//   request at a time, captures the returned word, presents {pc, pc+4, instr} to decode.
//   Sits directly upstream of the registered 32-bit adders. out_pc / out_pc_plus4 feed
//   the branch-target and link adders. Taken branches/jumps return as redirect_valid.
// PARAMETERS
//   WIDTH     32            PC / instruction width in bits
//   RESET_PC  32'h0000_0000 PC loaded on reset (bits [1:0] must be 0)
//   PC_STEP   4             sequential PC increment
// PORTS
//   clk            in   1      clock, all state updates on posedge
//   rst_n          in   1      asynchronous, active-low reset
//   redirect_valid in   1      load redirect_pc as next fetch PC (branch/jump taken)
//   redirect_pc    in   WIDTH  redirect target; bits [1:0] ignored (forced to 0)
//   req_valid      out  1      imem request valid
//   req_pc         out  WIDTH  imem request address
//   req_ready      in   1      imem accepts request when req_valid && req_ready
//   rsp_valid      in   1      imem response valid (one cycle, >=1 cycle after accept)
//   rsp_instr      in   WIDTH  imem response data
//   out_valid      out  1      fetched instruction available to decode
//   out_pc         out  WIDTH  PC of out_instr
//   out_pc_plus4   out  WIDTH  out_pc + PC_STEP, modulo 2^WIDTH
//   out_instr      out  WIDTH  fetched instruction
//   out_ready      in   1      decode consumes when out_valid && out_ready
//   fetch_count    out  32     number of instructions consumed by decode
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, kill=0; req_valid=0,
//     req_pc=RESET_PC, out_valid=0, out_pc=0, out_pc_plus4=0, out_instr=0, fetch_count=0.
//   All outputs registered or decoded from state; req_valid = (state==REQ), req_pc = pc.
//   States:
//   IDLE: one cycle after reset release -> REQ. redirect_valid here loads pc, still -> REQ.
//   REQ: req_valid=1. Accept (req_ready) -> WAIT. redirect_valid without accept: pc<=target,
//     stay REQ (req_pc changes next cycle). redirect_valid with accept: pc<=target, kill<=1, -> WAIT.
//   WAIT: req_valid=0. rsp_valid && !kill && !redirect_valid: out_instr<=rsp_instr,
//     out_pc<=pc, out_pc_plus4<=pc+PC_STEP, pc<=pc+PC_STEP, out_valid<=1 -> HOLD.
//     rsp_valid && kill: drop response, kill<=0 -> REQ.
//     redirect_valid without rsp_valid: pc<=target, kill<=1, stay WAIT.
//     redirect_valid with rsp_valid: drop response, pc<=target, kill<=0 -> REQ.
//   HOLD: out_valid=1, out_* stable. out_ready: out_valid<=0, fetch_count+=1 -> REQ.
//     redirect_valid: out_valid<=0, pc<=target, no count -> REQ (redirect beats out_ready).
//   Latency: accept-to-out_valid = 1 cycle after rsp_valid; consume-to-next req_valid = 1 cycle.
//   At most one request outstanding; rsp_valid outside WAIT is ignored.
//   Arithmetic: pc+PC_STEP wraps mod 2^WIDTH (32'hFFFF_FFFC -> 0); fetch_count wraps to 0.
//   Reset mid-request: outstanding response discarded; fetch restarts from RESET_PC.
// TESTING
//   Reset, req_ready=1, rsp 1 cycle later, out_ready=1 -> req_pc 0,4,8,...; out_pc/plus4 0/4, 4/8; fetch_count tracks.
//   out_ready=0 for 5 cycles in HOLD -> out_valid,out_instr stable, no new req_valid, count unchanged.
//   redirect_valid (pc 32'h40) during WAIT -> next rsp dropped, next req_pc=32'h40, out_pc=32'h40.
//   redirect_valid with rsp_valid same cycle, and with out_ready in HOLD -> no out_valid/count, req_pc=target.
//   RESET_PC=32'hFFFF_FFFC -> out_pc_plus4=0, following req_pc=0; redirect_pc=32'h43 -> req_pc=32'h40.
//   rst_n low while in WAIT, rsp arrives during reset -> all outputs reset, first req_pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word with its PC and PC+step until decode takes it.
module pc_fetch_unit #(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int             PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             req_valid,
    output logic [WIDTH-1:0] req_pc,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_instr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4,
    output logic [WIDTH-1:0] out_instr,
    input  logic             out_ready,
    output logic [31:0]      fetch_count
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_pc, w_pc_next;
    logic             r_kill, w_kill_next;
    logic             r_out_valid, w_out_valid_next;
    logic [WIDTH-1:0] r_out_pc, w_out_pc_next;
    logic [WIDTH-1:0] r_out_pc_plus4, w_out_pc_plus4_next;
    logic [WIDTH-1:0] r_out_instr, w_out_instr_next;
    logic [31:0]      r_fetch_count, w_fetch_count_next;

    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_unused_bits;

    assign w_target      = {redirect_pc[WIDTH-1:2], 2'b00};
    assign w_pc_inc      = r_pc + WIDTH'(PC_STEP);
    assign w_unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_kill         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_pc_plus4 <= '0;
            r_out_instr    <= '0;
            r_fetch_count  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_kill         <= w_kill_next;
            r_out_valid    <= w_out_valid_next;
            r_out_pc       <= w_out_pc_next;
            r_out_pc_plus4 <= w_out_pc_plus4_next;
            r_out_instr    <= w_out_instr_next;
            r_fetch_count  <= w_fetch_count_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_kill_next         = r_kill;
        w_out_valid_next    = r_out_valid;
        w_out_pc_next       = r_out_pc;
        w_out_pc_plus4_next = r_out_pc_plus4;
        w_out_instr_next    = r_out_instr;
        w_fetch_count_next  = r_fetch_count;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) w_pc_next = w_target;
                w_state_next = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) w_pc_next = w_target;
                if (req_ready) begin
                    // A redirect racing the accept leaves a stale request in flight.
                    w_kill_next  = redirect_valid;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_next = w_target;
                    if (rsp_valid) begin
                        w_kill_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_kill_next = 1'b1;
                    end
                end else if (rsp_valid) begin
                    if (r_kill) begin
                        w_kill_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_out_instr_next    = rsp_instr;
                        w_out_pc_next       = r_pc;
                        w_out_pc_plus4_next = w_pc_inc;
                        w_pc_next           = w_pc_inc;
                        w_out_valid_next    = 1'b1;
                        w_state_next        = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A redirect squashes the held instruction even if decode takes it.
                if (redirect_valid) begin
                    w_out_valid_next = 1'b0;
                    w_pc_next        = w_target;
                    w_state_next     = S_REQ;
                end else if (out_ready) begin
                    w_out_valid_next   = 1'b0;
                    w_fetch_count_next = r_fetch_count + 32'd1;
                    w_state_next       = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign req_valid    = (r_state == S_REQ);
    assign req_pc       = r_pc;
    assign out_valid    = r_out_valid;
    assign out_pc       = r_out_pc;
    assign out_pc_plus4 = r_out_pc_plus4;
    assign out_instr    = r_out_instr;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a default-reset instance for normal, stall,
// redirect and reset cases, plus an instance reset near the top of memory for wrap.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid, req_ready, rsp_valid, out_ready;
    logic [31:0] redirect_pc, rsp_instr;
    logic        req_valid, out_valid;
    logic [31:0] req_pc, out_pc, out_pc_plus4, out_instr, fetch_count;

    logic        wr_rst_n, wr_redirect_valid, wr_req_ready, wr_rsp_valid, wr_out_ready;
    logic [31:0] wr_redirect_pc, wr_rsp_instr;
    logic        wr_req_valid, wr_out_valid;
    logic [31:0] wr_req_pc, wr_out_pc, wr_out_pc_plus4, wr_out_instr, wr_fetch_count;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
        .out_valid(out_valid), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_instr(out_instr), .out_ready(out_ready), .fetch_count(fetch_count)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(wr_rst_n),
        .redirect_valid(wr_redirect_valid), .redirect_pc(wr_redirect_pc),
        .req_valid(wr_req_valid), .req_pc(wr_req_pc), .req_ready(wr_req_ready),
        .rsp_valid(wr_rsp_valid), .rsp_instr(wr_rsp_instr),
        .out_valid(wr_out_valid), .out_pc(wr_out_pc), .out_pc_plus4(wr_out_pc_plus4),
        .out_instr(wr_out_instr), .out_ready(wr_out_ready), .fetch_count(wr_fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Entered at a negedge with the DUT in REQ; leaves it back in REQ after the consume.
    task automatic fetch_one(input logic [31:0] instr, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        check_eq("f_req_valid", {31'd0, req_valid}, 32'd1);
        check_eq("f_req_pc", req_pc, exp_pc);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check_eq("f_wait_req_valid", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_instr = instr;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("f_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("f_out_instr", out_instr, instr);
        check_eq("f_out_pc", out_pc, exp_pc);
        check_eq("f_out_pc_plus4", out_pc_plus4, exp_pc + 32'd4);
        check_eq("f_count_hold", fetch_count, exp_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("f_out_valid_clr", {31'd0, out_valid}, 32'd0);
        check_eq("f_count_inc", fetch_count, exp_cnt + 32'd1);
        $display("fetch pc=%h instr=%h count=%0d", exp_pc, instr, exp_cnt + 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_instr = '0; out_ready = 1'b0;
        wr_rst_n = 1'b0; wr_redirect_valid = 1'b0; wr_redirect_pc = '0; wr_req_ready = 1'b0;
        wr_rsp_valid = 1'b0; wr_rsp_instr = '0; wr_out_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("rst_req_pc", req_pc, 32'h0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_count", fetch_count, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sequential fetches
        fetch_one(32'hA000_0000, 32'h0, 32'd0);
        fetch_one(32'hA000_0001, 32'h4, 32'd1);
        fetch_one(32'hA000_0002, 32'h8, 32'd2);

        // Decode stalls for 5 cycles in HOLD
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_instr = 32'hB0B0_B0B0;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_out_instr", out_instr, 32'hB0B0_B0B0);
            check_eq("stall_req_valid", {31'd0, req_valid}, 32'd0);
            check_eq("stall_count", fetch_count, 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("stall_count_after", fetch_count, 32'd4);
        check_eq("stall_next_req_pc", req_pc, 32'h10);
        $display("stall consumed pc=00000010 count=%0d", fetch_count);

        // Redirect during WAIT kills the outstanding response
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0; rsp_valid = 1'b1; rsp_instr = 32'hDEAD_DEAD;
        check_eq("kill_req_valid", {31'd0, req_valid}, 32'd0);
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("kill_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("kill_req_pc", req_pc, 32'h40);
        fetch_one(32'hC0C0_C0C0, 32'h40, 32'd4);

        // Redirect together with response in WAIT
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_instr = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        rsp_valid = 1'b0; redirect_valid = 1'b0;
        check_eq("rr_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rr_req_valid", {31'd0, req_valid}, 32'd1);
        check_eq("rr_req_pc", req_pc, 32'h80);
        check_eq("rr_count", fetch_count, 32'd5);

        // Redirect beats out_ready in HOLD
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_instr = 32'hEEEE_EEEE;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("rh_out_pc", out_pc, 32'h80);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        out_ready = 1'b0; redirect_valid = 1'b0;
        check_eq("rh_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rh_count", fetch_count, 32'd5);
        check_eq("rh_req_pc", req_pc, 32'h100);

        // Redirect in REQ without accept, low bits forced to zero
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("rq_req_valid", {31'd0, req_valid}, 32'd1);
        check_eq("rq_req_pc", req_pc, 32'h40);

        // Redirect together with accept in REQ
        redirect_valid = 1'b1; redirect_pc = 32'h200; req_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b1; rsp_instr = 32'h2222_2222;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_eq("ra_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("ra_req_pc", req_pc, 32'h200);

        // Reset while in WAIT, response arrives during reset
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; rst_n = 1'b0; rsp_valid = 1'b1; rsp_instr = 32'h3333_3333;
        #1;
        check_eq("mr_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("mr_req_pc", req_pc, 32'h0);
        check_eq("mr_out_pc", out_pc, 32'h0);
        check_eq("mr_count", fetch_count, 32'd0);
        @(negedge clk);
        rsp_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check_eq("mr_out_valid", {31'd0, out_valid}, 32'd0);
        fetch_one(32'hF0F0_F0F0, 32'h0, 32'd0);

        // Wrap instance: RESET_PC at top of address space
        wr_rst_n = 1'b1;
        @(negedge clk);
        check_eq("wr_req_pc", wr_req_pc, 32'hFFFF_FFFC);
        wr_req_ready = 1'b1;
        @(negedge clk);
        wr_req_ready = 1'b0; wr_rsp_valid = 1'b1; wr_rsp_instr = 32'h5555_5555;
        @(negedge clk);
        wr_rsp_valid = 1'b0;
        check_eq("wr_out_pc", wr_out_pc, 32'hFFFF_FFFC);
        check_eq("wr_out_pc_plus4", wr_out_pc_plus4, 32'h0);
        wr_out_ready = 1'b1;
        @(negedge clk);
        wr_out_ready = 1'b0;
        check_eq("wr_next_req_pc", wr_req_pc, 32'h0);
        check_eq("wr_count", wr_fetch_count, 32'd1);
        $display("wrap fetch pc=fffffffc next_pc=%h", wr_req_pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
